// File: rtl/stream_mux_pkg.sv
// Shared constants, select type and range helper for the stream mux family.
// Build option STREAM_MUX_SKID_EN (see stream_mux_reg) does not change this package.
package stream_mux_pkg;

    localparam int STREAM_MUX_MAX_N    = 16;
    localparam int STREAM_MUX_WIDTH    = 32;
    localparam int STREAM_MUX_MAX_SELW = $clog2(STREAM_MUX_MAX_N);

    typedef logic [STREAM_MUX_MAX_SELW-1:0] sel_t;

    function automatic logic sel_in_range(input sel_t sel, input int n);
        return (int'(sel) < n);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// One-entry skid buffer: upstream ready is registered, so it never depends
// combinationally on the downstream ready. Used only under STREAM_MUX_SKID_EN.
module stream_skid_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic             r_skid_full;
    logic [WIDTH-1:0] r_skid_data;

    assign o_s_ready = !r_skid_full;
    // A parked word always goes out ahead of anything arriving later.
    assign o_m_valid = r_skid_full || i_s_valid;
    assign o_m_data  = r_skid_full ? r_skid_data : i_s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
        end else if (i_s_valid && !r_skid_full && !i_m_ready) begin
            r_skid_full <= 1'b1;
            r_skid_data <= i_s_data;
        end else if (i_m_ready) begin
            r_skid_full <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_mux_reg.sv
// N-channel valid/ready stream mux with registered output and sticky bad-select flag.
// Define STREAM_MUX_SKID_EN to decouple in_ready from out_ready via a 1-entry skid buffer.
module stream_mux_reg
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = STREAM_MUX_WIDTH,
    parameter int N     = 3,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    logic [WIDTH-1:0] w_ch_data [N];
    logic             w_sel_ok;
    logic [SELW-1:0]  w_sel_idx;
    logic             w_src_valid;
    logic             w_src_ready;
    logic [WIDTH-1:0] w_src_data;
    logic             w_out_load;
    logic             w_reg_valid;
    logic [WIDTH-1:0] w_reg_data;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_sel_err;

    assign w_sel_ok    = sel_in_range(sel_t'(sel), N);
    // Park the index on channel 0 when out of range so the array read stays in bounds.
    assign w_sel_idx   = w_sel_ok ? sel : '0;
    assign w_src_valid = w_sel_ok && in_valid[w_sel_idx] && !rst;
    assign w_src_data  = w_ch_data[w_sel_idx];
    assign w_out_load  = !r_out_valid || out_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi]  = w_src_ready && !rst && (sel == SELW'(gi));
        end
    endgenerate

`ifdef STREAM_MUX_SKID_EN
    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_s_valid (w_src_valid),
        .o_s_ready (w_src_ready),
        .i_s_data  (w_src_data),
        .o_m_valid (w_reg_valid),
        .i_m_ready (w_out_load),
        .o_m_data  (w_reg_data)
    );
`else
    assign w_src_ready = w_out_load;
    assign w_reg_valid = w_src_valid;
    assign w_reg_data  = w_src_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_out_valid <= w_reg_valid;
                if (w_reg_valid) begin
                    r_out_data <= w_reg_data;
                end
            end
            if (!w_sel_ok && (|in_valid)) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_stream_mux_reg.sv
// Self-checking bench for stream_mux_reg (N=3, WIDTH=32); directed scenarios plus a
// random run against a queue model. Skid scenario compiled when STREAM_MUX_SKID_EN is set.
module tb_stream_mux_reg;

    localparam int N    = 3;
    localparam int W    = 32;
    localparam int SELW = 2;
`ifdef STREAM_MUX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [SELW-1:0]  sel;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;

    int n_vec = 0;
    int n_err = 0;

    stream_mux_reg #(.WIDTH(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
        in_data = {32'h3, 32'h2, 32'h1};
        #1;
        n_vec++;
        if (in_ready !== 3'b000) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 000", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || sel_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h e=%b expected v=0 d=0 e=0", out_valid, out_data, sel_err);
        end
        rst = 1'b0; in_valid = '0;
        $display("reset: checked");
    endtask

    task automatic test_basic();
        out_ready = 1'b1; sel = 2'd1; in_valid = 3'b010;
        in_data = {32'h0, 32'hDEADBEEF, 32'h0};
        #1;
        n_vec++;
        if (in_ready !== 3'b010) begin
            n_err++; $display("FAIL basic_in_ready: got %b expected 010", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL basic_out: got v=%b d=%h expected v=1 d=deadbeef", out_valid, out_data);
        end
        in_valid = '0;
        $display("basic: sel=1 data=deadbeef");
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_rdy;
        out_ready = 1'b1; in_valid = '1;
        for (int k = 0; k < 4; k++) begin
            sel = SELW'(k % 3);
            for (int c = 0; c < N; c++) in_data[c*W +: W] = 32'hFFFF0000 | 32'(c);
            in_data[(k % 3)*W +: W] = 32'h10 + 32'(k);
            exp_rdy = 3'b001 << (k % 3);
            #1;
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL b2b_in_ready[%0d]: got %b expected %b", k, in_ready, exp_rdy);
            end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 32'h10 + 32'(k)) begin
                n_err++;
                $display("FAIL b2b_out[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, 32'h10 + 32'(k));
            end
            $display("b2b: sel=%0d data=%h", k % 3, 32'h10 + 32'(k));
        end
        in_valid = '0;
    endtask

    task automatic test_stall();
        logic [N-1:0] exp_rdy;
        out_ready = 1'b1; sel = 2'd0; in_valid = 3'b001;
        in_data = {32'h0, 32'h0, 32'hA5A5A5A5};
        tick();
        in_data[0 +: W] = 32'h5A5A5A5A;
        for (int s = 0; s < 3; s++) begin
            out_ready = 1'b0;
            exp_rdy = (SKID && s == 0) ? 3'b001 : 3'b000;
            #1;
            n_vec++;
            if (in_ready !== exp_rdy || out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin
                n_err++;
                $display("FAIL stall[%0d]: got r=%b v=%b d=%h expected r=%b v=1 d=a5a5a5a5", s, in_ready, out_valid, out_data, exp_rdy);
            end
            tick();
        end
        out_ready = 1'b1;
        exp_rdy = SKID ? 3'b000 : 3'b001;
        #1;
        n_vec++;
        if (in_ready !== exp_rdy || out_data !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL stall_release: got r=%b d=%h expected r=%b d=a5a5a5a5", in_ready, out_data, exp_rdy);
        end
        tick();
        in_valid = '0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h5A5A5A5A) begin
            n_err++; $display("FAIL stall_next: got v=%b d=%h expected v=1 d=5a5a5a5a", out_valid, out_data);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_drain: got v=%b expected v=0", out_valid);
        end
        $display("stall: held a5a5a5a5, then 5a5a5a5a");
    endtask

    task automatic test_out_of_range();
        do_reset();
        out_ready = 1'b1; sel = 2'd3; in_valid = 3'b111;
        #1;
        n_vec++;
        if (in_ready !== 3'b000) begin
            n_err++; $display("FAIL oor_in_ready: got %b expected 000", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || sel_err !== 1'b1) begin
            n_err++; $display("FAIL oor_flag: got v=%b e=%b expected v=0 e=1", out_valid, sel_err);
        end
        sel = 2'd0; in_valid = '0;
        repeat (10) tick();
        n_vec++;
        if (sel_err !== 1'b1) begin
            n_err++; $display("FAIL oor_sticky: got e=%b expected e=1", sel_err);
        end
        $display("out_of_range: sel=3 flagged");
    endtask

    task automatic test_reset_mid();
        sel = 2'd1; in_valid = 3'b010; out_ready = 1'b0;
        in_data = {32'h0, 32'h12345678, 32'h0};
        tick();
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL rstmid_loaded: got v=%b expected v=1", out_valid);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 3'b000) begin
            n_err++; $display("FAIL rstmid_in_ready: got %b expected 000", in_ready);
        end
        tick();
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || sel_err !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_state: got v=%b d=%h e=%b expected v=0 d=0 e=0", out_valid, out_data, sel_err);
        end
        in_valid = '0; out_ready = 1'b1;
        $display("reset_mid: pending word dropped");
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        bit           m_err;
        logic [N-1:0] exp_rdy;
        bit           slot;
        do_reset();
        m_err = 1'b0;
        for (int t = 0; t < 400; t++) begin
            sel = SELW'($urandom_range(0, 3));
            in_valid = 3'($urandom);
            for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            slot = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
            exp_rdy = (int'(sel) < N && slot) ? (3'b001 << sel) : 3'b000;
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", t, in_ready, exp_rdy);
            end
            n_vec++;
            if (out_valid !== (q.size() != 0) || (q.size() != 0 && out_data !== q[0])) begin
                n_err++;
                $display("FAIL rnd_out[%0d]: got v=%b d=%h expected v=%b d=%h", t, out_valid, out_data,
                         q.size() != 0, (q.size() != 0) ? q[0] : 32'h0);
            end
            n_vec++;
            if (sel_err !== m_err) begin
                n_err++; $display("FAIL rnd_sel_err[%0d]: got %b expected %b", t, sel_err, m_err);
            end
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (int'(sel) < N && slot && in_valid[sel]) begin
                q.push_back(in_data[sel*W +: W]);
                $display("rnd %0d: ch%0d -> %h", t, sel, in_data[sel*W +: W]);
            end
            if (int'(sel) >= N && (|in_valid)) m_err = 1'b1;
            tick();
        end
        in_valid = '0;
    endtask

`ifdef STREAM_MUX_SKID_EN
    task automatic test_skid();
        do_reset();
        out_ready = 1'b0; sel = 2'd0; in_valid = 3'b001;
        in_data = {32'h0, 32'h0, 32'h1};
        tick();
        in_data[0 +: W] = 32'h2;
        #1;
        n_vec++;
        if (in_ready !== 3'b001 || out_data !== 32'h1) begin
            n_err++; $display("FAIL skid_second: got r=%b d=%h expected r=001 d=1", in_ready, out_data);
        end
        tick();
        in_valid = '0;
        #1;
        n_vec++;
        if (in_ready !== 3'b000 || out_valid !== 1'b1 || out_data !== 32'h1) begin
            n_err++; $display("FAIL skid_full: got r=%b v=%b d=%h expected r=000 v=1 d=1", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h2) begin
            n_err++; $display("FAIL skid_drain: got v=%b d=%h expected v=1 d=2", out_valid, out_data);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL skid_empty: got v=%b expected v=0", out_valid);
        end
        $display("skid: 1 then 2 in order");
    endtask
`endif

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_out_of_range();
        test_reset_mid();
        test_random();
`ifdef STREAM_MUX_SKID_EN
        test_skid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_reg.md
Name: stream_mux_reg

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a valid/ready handshake and a registered output stage.
- Successor to the fixed 3:1 combinational 32-bit select used in the pipeline datapath.
- Sits between producers (LSU response, UART RX, CSR read path) and a single consumer (writeback / bus return).
- Adds back-pressure, select sampling at transfer boundaries and out-of-range select detection.

Parameters:
- WIDTH, 32, data width per channel.
- N, 3, number of input channels (2..16).
- SELW, $clog2(N), select width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready.
- sel  input  SELW  channel select, sampled on transfer.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output holds valid data.
- out_ready  input  1  consumer ready.
- sel_err  output  1  sticky: out-of-range sel seen while any in_valid high.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_data = 0, out_valid = 0, sel_err = 0. in_ready = 0 during reset.
- load = !out_valid || out_ready (output slot free or draining this cycle).
- in_ready[i] = load && (sel == i) && !rst. All other channels see ready = 0.
- Input transfer on channel i: in_valid[i] && in_ready[i]. Next cycle out_data = in_data[i] and out_valid = 1.
  - Latency is exactly 1 cycle from input transfer to out_valid.
- Output transfer: out_valid && out_ready.
  - Without a simultaneous input transfer, out_valid drops to 0 next cycle.
  - With a simultaneous input transfer, out_valid stays 1 and out_data takes the new value: full throughput, 1 word/cycle.
- Stall: out_valid && !out_ready holds out_data and out_valid stable, and all in_ready stay 0.
- sel may change any cycle. Only the value present in a transfer cycle matters; no locking across cycles.
- Out-of-range sel (sel >= N, possible when N is not a power of two):
  - no channel is readied and out_valid is not set;
  - if any in_valid is high, sel_err sets next cycle and stays set until rst.
- Selected channel with in_valid = 0: no transfer; out_valid clears if the output drained.
- Reset mid-operation: the pending output word is discarded, out_valid = 0 next cycle, and no in_ready is asserted in the rst cycle.
- State: 2-state implicit FSM on out_valid.
  - EMPTY → FULL on input transfer.
  - FULL → EMPTY on output transfer without input transfer.
  - FULL → FULL on stall or on a simultaneous output and input transfer.

Optional Feature:
- Macro: STREAM_MUX_SKID_EN.
- Defined:
  - in_ready no longer depends combinationally on out_ready. A 1-entry skid buffer is inserted: load = !skid_full.
  - A word accepted while the output is stalled goes to skid.
  - Skid drains to the output on the next output transfer, in order.
  - Throughput stays 1/cycle. Latency is 1 cycle, or 2 when taken via skid.
  - rst clears skid_full.
- Undefined: behaviour exactly as above; no skid storage.

Decomposition:
- Package stream_mux_pkg:
  - constants STREAM_MUX_MAX_N = 16 and default STREAM_MUX_WIDTH = 32;
  - typedef sel_t sized to the max select width;
  - function sel_in_range(sel, n).
- Sub-module stream_skid_buf (WIDTH; 1-entry valid/ready skid buffer) is instantiated only under STREAM_MUX_SKID_EN.
- The mux select and the output register stay in the top module.

Test Plan:
- N=3, WIDTH=32, out_ready = 1. sel = 1, in_valid = 3'b010, in_data[1] = 0xDEADBEEF → in_ready = 3'b010; next cycle out_valid = 1, out_data = 0xDEADBEEF.
- Back-to-back: sel = 0,1,2,0 on consecutive cycles, all in_valid = 1, data 0x10, 0x11, 0x12, 0x13 → out_data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles, out_valid held at 1.
- Stall: out_ready = 0 for 3 cycles with out_data = 0xA5A5A5A5 → out_data stable, in_ready = 0 throughout. out_ready = 1 → one transfer, then the next word loads.
- Out of range: N=3, sel = 3, in_valid = 3'b111 → in_ready = 0, out_valid = 0, sel_err = 1 next cycle and still 1 after 10 cycles.
- Reset mid-operation: out_valid = 1, out_ready = 0, rst = 1 for one cycle → next cycle out_valid = 0, out_data = 0, sel_err = 0.
- STREAM_MUX_SKID_EN: out_ready = 0 while sending 0x1 then 0x2 → first word at the output, second in skid, in_ready = 0. out_ready = 1 → 0x1 then 0x2 on consecutive cycles.
